// File: rtl/pixel_blob_locator.sv
// Colour-blob centroid finder on the XVGA pixel stream: accumulates matching pixel
// coordinates per frame and divides them at each vsync falling edge.
module pixel_blob_locator #(
  parameter logic [23:0] TARGET_COLOR = 24'hFF_00_00,
  parameter logic [7:0]  TOLERANCE    = 8'd32,
  parameter logic [19:0] MIN_COUNT    = 20'd16,
  parameter int          TOTAL_WIDTH  = 1024,
  parameter int          TOTAL_HEIGHT = 768
) (
  input  logic               vclock,
  input  logic               reset,
  input  logic [23:0]        pixel,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               blank,
  input  logic               vsync,
  output logic signed [11:0] centroid_x,
  output logic signed [11:0] centroid_y,
  output logic [19:0]        pixel_count,
  output logic               found,
  output logic               done,
  output logic               busy
);

  localparam logic [11:0] X_OFFSET  = 12'(TOTAL_WIDTH / 2);
  localparam logic [11:0] Y_BASE    = 12'(TOTAL_HEIGHT);
  localparam logic [4:0]  LAST_ITER = 5'd29;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state;
  logic        prev_vsync;
  logic        frame_edge;
  logic        pixel_match;
  logic [29:0] sum_x;
  logic [29:0] sum_y;
  logic [19:0] acc_count;
  logic [29:0] quo_x;
  logic [29:0] quo_y;
  logic [19:0] rem_x;
  logic [19:0] rem_y;
  logic [19:0] divisor;
  logic [19:0] op_count;
  logic [4:0]  iter;
  logic [29:0] next_quo_x;
  logic [29:0] next_quo_y;
  logic [19:0] next_rem_x;
  logic [19:0] next_rem_y;

  function automatic logic chan_ok(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff <= TOLERANCE);
  endfunction

  // One restoring-division step: the dividend shifts out of the top of quo while
  // quotient bits shift in at the bottom, so after 30 steps quo holds the quotient.
  function automatic logic [49:0] div_step(input logic [19:0] rem,
                                           input logic [29:0] quo,
                                           input logic [19:0] dsr);
    logic [20:0] trial;
    logic [20:0] diff;
    trial = {rem, quo[29]};
    diff  = trial - {1'b0, dsr};
    if (trial >= {1'b0, dsr})
      return {diff[19:0], quo[28:0], 1'b1};
    else
      return {trial[19:0], quo[28:0], 1'b0};
  endfunction

  always_comb begin
    pixel_match = !blank
                  && chan_ok(pixel[23:16], TARGET_COLOR[23:16])
                  && chan_ok(pixel[15:8],  TARGET_COLOR[15:8])
                  && chan_ok(pixel[7:0],   TARGET_COLOR[7:0]);
    frame_edge  = prev_vsync && !vsync;
    {next_rem_x, next_quo_x} = div_step(rem_x, quo_x, divisor);
    {next_rem_y, next_quo_y} = div_step(rem_y, quo_y, divisor);
  end

  // The edge cycle wins over a coincident match: that pixel is dropped.
  always_ff @(posedge vclock) begin
    if (reset) begin
      prev_vsync <= 1'b1;
      sum_x      <= '0;
      sum_y      <= '0;
      acc_count  <= '0;
    end else begin
      prev_vsync <= vsync;
      if (frame_edge) begin
        sum_x     <= '0;
        sum_y     <= '0;
        acc_count <= '0;
      end else if (pixel_match && (acc_count != '1)) begin
        sum_x     <= sum_x + {19'd0, hcount};
        sum_y     <= sum_y + {20'd0, vcount};
        acc_count <= acc_count + 20'd1;
      end
    end
  end

  // Edges seen outside IDLE only clear the accumulators; the running division continues.
  always_ff @(posedge vclock) begin
    if (reset) begin
      state       <= IDLE;
      quo_x       <= '0;
      quo_y       <= '0;
      rem_x       <= '0;
      rem_y       <= '0;
      divisor     <= '0;
      op_count    <= '0;
      iter        <= '0;
      centroid_x  <= '0;
      centroid_y  <= '0;
      pixel_count <= '0;
      found       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_edge) begin
            quo_x    <= sum_x;
            quo_y    <= sum_y;
            rem_x    <= '0;
            rem_y    <= '0;
            divisor  <= (acc_count == '0) ? 20'd1 : acc_count;
            op_count <= acc_count;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          quo_x <= next_quo_x;
          quo_y <= next_quo_y;
          rem_x <= next_rem_x;
          rem_y <= next_rem_y;
          iter  <= iter + 5'd1;
          if (iter == LAST_ITER)
            state <= DONE;
        end
        DONE: begin
          pixel_count <= op_count;
          found       <= (op_count >= MIN_COUNT);
          if (op_count >= MIN_COUNT) begin
            centroid_x <= quo_x[11:0] - X_OFFSET;
            centroid_y <= Y_BASE - quo_y[11:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
